// File: rtl/msg_tx_ctrl.sv
// Master-message transmit controller: arbitrates one-hot requests and
// serialises marker, flag, payload and optional checksum bytes to the coder.
module msg_tx_ctrl #(
  parameter int               N_MSG  = 3,
  parameter int               PL_LEN = 2,
  parameter bit               CS_EN  = 1'b0,
  parameter logic [7:0]       MARKER = 8'hA5,
  parameter logic [8*N_MSG-1:0] FLAGS = {8'h03, 8'h02, 8'h01}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_MSG-1:0] tx_req,
  input  logic             cd_busy,
  input  logic [7:0]       pl_data,
  output logic [3:0]       pl_idx,
  output logic             pl_rd,
  output logic [7:0]       q,
  output logic             q_rdy,
  output logic             msg_active,
  output logic [2:0]       msg_id,
  output logic             msg_end,
  output logic             msg_abort
);

  typedef enum logic [2:0] {
    S_IDLE, S_MARK, S_FLAG, S_PAYLD, S_CSUM, S_DONE
  } state_t;

  localparam logic [3:0] LAST =
    (PL_LEN > 0) ? 4'(PL_LEN - 1) : 4'd0;
  localparam state_t AFTER_PL =
    CS_EN ? S_CSUM : S_DONE;
  localparam state_t AFTER_FLAG =
    (PL_LEN > 0) ? S_PAYLD : AFTER_PL;

  state_t     state_q, state_d;
  logic       busy_q;
  logic [7:0] csum_q, csum_d;
  logic [3:0] idx_q, idx_d;
  logic [2:0] id_q, id_d;
  logic       end_q, end_d;
  logic       abort_q, abort_d;
  logic       ack, byte_st, req_on;
  logic [7:0] flag_b;
  logic [2:0] first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      csum_q  <= 8'h00;
      idx_q   <= 4'd0;
      id_q    <= 3'd0;
      end_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= cd_busy;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      end_q   <= end_d;
      abort_q <= abort_d;
    end
  end

  // flag byte and request level of the latched type, plus
  // lowest-index pending request for the next start
  always_comb begin
    flag_b = 8'h00;
    req_on = 1'b0;
    first  = 3'd0;
    for (int i = 0; i < N_MSG; i++) begin
      if (id_q == 3'(i)) begin
        flag_b = FLAGS[8*i +: 8];
        req_on = tx_req[i];
      end
    end
    for (int i = N_MSG - 1; i >= 0; i--) begin
      if (tx_req[i]) first = 3'(i);
    end
  end

  assign ack = cd_busy & ~busy_q;
  assign byte_st = (state_q == S_MARK) || (state_q == S_FLAG) ||
                   (state_q == S_PAYLD) || (state_q == S_CSUM);

  always_comb begin
    state_d = state_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    id_d    = id_q;
    end_d   = 1'b0;
    abort_d = 1'b0;
    q       = 8'h00;
    q_rdy   = 1'b0;
    pl_rd   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|tx_req) begin
          id_d    = first;
          csum_d  = 8'h00;
          state_d = S_MARK;
        end
      end
      S_MARK: begin
        q = MARKER;
        if (ack) state_d = S_FLAG;
      end
      S_FLAG: begin
        q = flag_b;
        if (ack) begin
          csum_d  = csum_q ^ flag_b;
          state_d = AFTER_FLAG;
        end
      end
      S_PAYLD: begin
        q = pl_data;
        if (ack) begin
          pl_rd  = 1'b1;
          csum_d = csum_q ^ pl_data;
          if (idx_q == LAST) begin
            idx_d   = 4'd0;
            state_d = AFTER_PL;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_CSUM: begin
        q = csum_q;
        if (ack) state_d = S_DONE;
      end
      S_DONE: begin
        if (!cd_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (byte_st) begin
      q_rdy = ~cd_busy;
      end_d = (state_d == S_DONE);
    end
    // a dropped request overrides any same-cycle byte advance
    if (byte_st && !req_on) begin
      state_d = S_IDLE;
      idx_d   = 4'd0;
      csum_d  = 8'h00;
      pl_rd   = 1'b0;
      end_d   = 1'b0;
      abort_d = 1'b1;
    end
  end

  assign pl_idx     = idx_q;
  assign msg_id     = id_q;
  assign msg_active = (state_q != S_IDLE);
  assign msg_end    = end_q;
  assign msg_abort  = abort_q;

endmodule
